// File: rtl/reg_scoreboard_if.sv
// Issue, writeback and register-file write bundle for reg_scoreboard.
// master = decode/writeback side, slave = the scoreboard itself.
interface reg_scoreboard_if #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic            flush;
    logic            iss_valid;
    logic [AW-1:0]   iss_rs1;
    logic [AW-1:0]   iss_rs2;
    logic [AW-1:0]   iss_rd;
    logic            iss_wr;
    logic            iss_ready;
    logic            wb0_valid;
    logic [AW-1:0]   wb0_rd;
    logic [DW-1:0]   wb0_data;
    logic            wb0_ready;
    logic            wb1_valid;
    logic [AW-1:0]   wb1_rd;
    logic [DW-1:0]   wb1_data;
    logic            wb1_ready;
    logic            rf_we;
    logic [AW-1:0]   rf_a3;
    logic [DW-1:0]   rf_wd;
    logic [NREG-1:0] busy_vec;

    modport master (
        output flush, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr,
        output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
        input  iss_ready, wb0_ready, wb1_ready, rf_we, rf_a3, rf_wd, busy_vec
    );

    modport slave (
        input  flush, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr,
        input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
        output iss_ready, wb0_ready, wb1_ready, rf_we, rf_a3, rf_wd, busy_vec
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard with RAW/WAW issue stall and round-robin arbitration of the RF write port.
// Define SB_BYPASS_EN to let a waiting instruction issue in the same cycle as its writeback.
module reg_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic             clk,
    input  logic             rst,
    reg_scoreboard_if.slave  bus
);
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic            rr_last_reg;

    logic            grant0;
    logic            grant1;
    logic            grant_any;
    logic [AW-1:0]   grant_rd;
    logic [DW-1:0]   grant_data;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] busy_eff;
    logic            hit_rs1;
    logic            hit_rs2;
    logic            hit_rd;
    logic            iss_fire;

    // rr_last_reg = 1 means wb1 won last, so wb0 takes the next conflict.
    assign grant0    = bus.wb0_valid & (~bus.wb1_valid | rr_last_reg);
    assign grant1    = bus.wb1_valid & (~bus.wb0_valid | ~rr_last_reg);
    assign grant_any = grant0 | grant1;

    always_comb begin
        grant_rd   = '0;
        grant_data = '0;
        if (grant0) begin
            grant_rd   = bus.wb0_rd;
            grant_data = bus.wb0_data;
        end else if (grant1) begin
            grant_rd   = bus.wb1_rd;
            grant_data = bus.wb1_data;
        end
    end

    assign bus.wb0_ready = grant0;
    assign bus.wb1_ready = grant1;
    assign bus.rf_we     = grant_any & (grant_rd != '0);
    assign bus.rf_a3     = grant_rd;
    assign bus.rf_wd     = grant_data;
    assign bus.busy_vec  = busy_reg;

    // Register 0 is hardwired zero, so bit 0 is never set or cleared.
    assign clr_vec[0] = 1'b0;
    assign set_vec[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_vec
            assign clr_vec[gi] = grant_any & (grant_rd == AW'(gi));
            assign set_vec[gi] = iss_fire & bus.iss_wr & (bus.iss_rd == AW'(gi));
        end
    endgenerate

`ifdef SB_BYPASS_EN
    // The RF forwards same-cycle write data, so a register being written now is safe to read.
    assign busy_eff = busy_reg & ~clr_vec;
`else
    assign busy_eff = busy_reg;
`endif

    assign hit_rs1 = (bus.iss_rs1 != '0) & busy_eff[bus.iss_rs1];
    assign hit_rs2 = (bus.iss_rs2 != '0) & busy_eff[bus.iss_rs2];
    assign hit_rd  = (bus.iss_rd  != '0) & busy_eff[bus.iss_rd];

    assign bus.iss_ready = ~bus.flush & ~hit_rs1 & ~hit_rs2 & ~(bus.iss_wr & hit_rd);
    assign iss_fire      = bus.iss_valid & bus.iss_ready;

    // A set applied after the clear means a same-cycle reissue of the register keeps it busy.
    assign busy_next = bus.flush ? '0 : ((busy_reg & ~clr_vec) | set_vec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg    <= '0;
            rr_last_reg <= 1'b1;
        end else begin
            busy_reg <= busy_next;
            if (grant0) begin
                rr_last_reg <= 1'b0;
            end else if (grant1) begin
                rr_last_reg <= 1'b1;
            end
        end
    end
endmodule
